// File: rtl/demm_pkg.sv
// Shared types and constants for the DEMM row scheduler and its lane credit
// counters.
package demm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        LOAD_B,
        WAIT_B,
        DISPATCH,
        DRAIN,
        DONE
    } demm_state_e;

    localparam int ELEM_BYTES_DEF = 2;
    localparam int CREDIT_W       = 3;

    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demm_lane_credit.sv
// Outstanding-row counter for one kernel lane; flags completions that arrive
// when nothing is outstanding.
module demm_lane_credit
    import demm_pkg::*;
#(
    parameter int MAX_OUT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic has_credit,
    output logic nonzero,
    output logic spurious
);

    logic [CREDIT_W-1:0] cnt_q, cnt_d;
    logic                dec_ok;

    always_comb begin
        nonzero    = (cnt_q != '0);
        dec_ok     = dec && nonzero;
        spurious   = dec && !nonzero;
        has_credit = (cnt_q < CREDIT_W'(MAX_OUT));
        cnt_d      = cnt_q;
        if (inc && !dec_ok) begin
            cnt_d = cnt_q + CREDIT_W'(1);
        end else if (!inc && dec_ok) begin
            cnt_d = cnt_q - CREDIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demm_row_scheduler.sv
// Sequences one DEMM job: one B load descriptor, then A rows dealt round-robin
// to the kernel lanes, then calc_end once every row has completed.
module demm_row_scheduler
    import demm_pkg::*;
#(
    parameter int              ISSUE_NUM   = 4,
    parameter int              ADDR_W      = 64,
    parameter logic [ADDR_W-1:0] A_BASE_ADDR = ADDR_W'(32'h1000_0000),
    parameter logic [ADDR_W-1:0] B_BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] O_BASE_ADDR = ADDR_W'(32'h2000_0000),
    parameter int              ELEM_BYTES  = ELEM_BYTES_DEF,
    parameter int              MAX_OUT     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 calc_begin,
    input  logic [31:0]          M_num,
    input  logic [31:0]          N_num,
    input  logic [31:0]          K_num,
    output logic                 busy,
    output logic                 calc_end,
    output logic                 err,
    output logic                 b_req_valid,
    input  logic                 b_req_ready,
    output logic [ADDR_W-1:0]    b_req_addr,
    output logic [31:0]          b_req_len,
    input  logic                 b_done,
    output logic [ISSUE_NUM-1:0] lane_valid,
    input  logic [ISSUE_NUM-1:0] lane_ready,
    output logic [ADDR_W-1:0]    job_a_addr,
    output logic [ADDR_W-1:0]    job_o_addr,
    output logic [31:0]          job_row,
    input  logic [ISSUE_NUM-1:0] lane_done
);

    localparam int LW = lane_w(ISSUE_NUM);

    demm_state_e         state_q, state_d;
    logic                busy_q, busy_d;
    logic                end_q, end_d;
    logic                err_q, err_d;
    logic                bval_q, bval_d;
    logic [31:0]         m_q, m_d, n_q, n_d, k_q, k_d;
    logic [31:0]         blen_q, blen_d;
    logic [ADDR_W-1:0]   sa_q, sa_d, so_q, so_d;
    logic [ADDR_W-1:0]   aaddr_q, aaddr_d, oaddr_q, oaddr_d;
    logic [31:0]         row_q, row_d;
    logic [31:0]         dcnt_q, dcnt_d;
    logic [LW-1:0]       ptr_q, ptr_d;

    logic [ISSUE_NUM-1:0] sel, has_credit, nonzero, spurious;
    logic                 accept, start;
    logic [31:0]          done_inc;

    always_comb begin
        sel      = '0;
        done_inc = '0;
        for (int l = 0; l < ISSUE_NUM; l++) begin
            sel[l]   = (ptr_q == LW'(l));
            done_inc = done_inc + 32'(lane_done[l] & nonzero[l]);
        end
    end

    assign lane_valid = (state_q == DISPATCH) ? (sel & has_credit) : '0;
    assign accept     = |(lane_valid & lane_ready);
    // busy_q still covers the calc_end cycle, so a start there is dropped
    assign start      = calc_begin && (state_q == IDLE) && !busy_q;

    for (genvar l = 0; l < ISSUE_NUM; l++) begin : g_lane
        demm_lane_credit #(
            .MAX_OUT(MAX_OUT)
        ) u_credit (
            .clk       (clk),
            .rst       (rst),
            .inc       (lane_valid[l] & lane_ready[l]),
            .dec       (lane_done[l]),
            .has_credit(has_credit[l]),
            .nonzero   (nonzero[l]),
            .spurious  (spurious[l])
        );
    end

    always_comb begin
        state_d = state_q;
        bval_d  = bval_q;
        m_d     = m_q;
        n_d     = n_q;
        k_d     = k_q;
        blen_d  = blen_q;
        sa_d    = sa_q;
        so_d    = so_q;
        aaddr_d = aaddr_q;
        oaddr_d = oaddr_q;
        row_d   = row_q;
        dcnt_d  = dcnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = M_num;
                    n_d     = N_num;
                    k_d     = K_num;
                    state_d = CFG;
                end
            end
            CFG: begin
                sa_d    = ADDR_W'(k_q) * ADDR_W'(ELEM_BYTES);
                so_d    = ADDR_W'(n_q) * ADDR_W'(ELEM_BYTES);
                blen_d  = n_q * k_q * 32'(ELEM_BYTES);
                aaddr_d = A_BASE_ADDR;
                oaddr_d = O_BASE_ADDR;
                row_d   = '0;
                dcnt_d  = '0;
                ptr_d   = '0;
                if (m_q == '0 || n_q == '0 || k_q == '0) begin
                    state_d = DONE;
                end else begin
                    bval_d  = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (b_req_ready) begin
                    bval_d  = 1'b0;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (b_done) state_d = DISPATCH;
            end
            DISPATCH: begin
                if (accept) begin
                    row_d   = row_q + 32'd1;
                    aaddr_d = aaddr_q + sa_q;
                    oaddr_d = oaddr_q + so_q;
                    ptr_d   = (ptr_q == LW'(ISSUE_NUM - 1)) ? '0 : ptr_q + LW'(1);
                    if (row_q == m_q - 32'd1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dcnt_q == m_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q == DISPATCH || state_q == DRAIN) begin
            dcnt_d = dcnt_q + done_inc;
        end
        end_d  = (state_q == DONE);
        busy_d = (state_d != IDLE) || end_d;
        err_d  = (start ? 1'b0 : err_q) | (|spurious);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
            bval_q  <= 1'b0;
            m_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            blen_q  <= '0;
            sa_q    <= '0;
            so_q    <= '0;
            aaddr_q <= '0;
            oaddr_q <= '0;
            row_q   <= '0;
            dcnt_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
            err_q   <= err_d;
            bval_q  <= bval_d;
            m_q     <= m_d;
            n_q     <= n_d;
            k_q     <= k_d;
            blen_q  <= blen_d;
            sa_q    <= sa_d;
            so_q    <= so_d;
            aaddr_q <= aaddr_d;
            oaddr_q <= oaddr_d;
            row_q   <= row_d;
            dcnt_q  <= dcnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy        = busy_q;
    assign calc_end    = end_q;
    assign err         = err_q;
    assign b_req_valid = bval_q;
    assign b_req_addr  = bval_q ? B_BASE_ADDR : '0;
    assign b_req_len   = blen_q;
    assign job_a_addr  = aaddr_q;
    assign job_o_addr  = oaddr_q;
    assign job_row     = row_q;

endmodule

// File: tb/tb_demm_row_scheduler.sv
// Scoreboard bench for demm_row_scheduler: expected row descriptors are queued
// at job start and popped as lanes accept them; lanes answer 5 cycles later.
module tb_demm_row_scheduler;

    localparam int          NL     = 4;
    localparam int          AW     = 64;
    localparam logic [63:0] A_BASE = 64'h1000_0000;
    localparam logic [63:0] O_BASE = 64'h2000_0000;

    logic          clk = 1'b0;
    logic          rst, calc_begin;
    logic [31:0]   M_num, N_num, K_num;
    logic          busy, calc_end, err;
    logic          b_req_valid, b_req_ready, b_done;
    logic [AW-1:0] b_req_addr, job_a_addr, job_o_addr;
    logic [31:0]   b_req_len, job_row;
    logic [NL-1:0] lane_valid, lane_ready, lane_done;

    typedef struct {
        int          lane;
        logic [31:0] row;
        logic [63:0] a;
        logic [63:0] o;
    } exp_t;

    exp_t          exp_q[$];
    int            due_q[NL][$];
    logic [NL-1:0] hold = '0, kick = '0, inj = '0;
    int ncyc = 0, delivered = 0, job_m = 0, end_cnt = 0;
    int acc_cnt = 0, bv_cnt = 0, lv_cnt = 0;
    int errors = 0, checks = 0;

    demm_row_scheduler #(
        .ISSUE_NUM(NL),
        .ADDR_W   (AW),
        .MAX_OUT  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .calc_begin (calc_begin),
        .M_num      (M_num),
        .N_num      (N_num),
        .K_num      (K_num),
        .busy       (busy),
        .calc_end   (calc_end),
        .err        (err),
        .b_req_valid(b_req_valid),
        .b_req_ready(b_req_ready),
        .b_req_addr (b_req_addr),
        .b_req_len  (b_req_len),
        .b_done     (b_done),
        .lane_valid (lane_valid),
        .lane_ready (lane_ready),
        .job_a_addr (job_a_addr),
        .job_o_addr (job_o_addr),
        .job_row    (job_row),
        .lane_done  (lane_done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Lane model and acceptance monitor
    initial begin
        exp_t e;
        lane_done = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            lane_done = inj;
            inj = '0;
            for (int l = 0; l < NL; l++) begin
                if (due_q[l].size() > 0 &&
                    (kick[l] || (!hold[l] && due_q[l][0] <= ncyc))) begin
                    lane_done[l] = 1'b1;
                    void'(due_q[l].pop_front());
                    delivered++;
                end
            end
            kick = '0;
            #1;
            if (calc_end) begin
                end_cnt++;
                check("rows_done_at_end", 64'(delivered), 64'(job_m));
            end
            if (b_req_valid) bv_cnt++;
            if (lane_valid != '0) lv_cnt++;
            if (!rst) begin
                for (int l = 0; l < NL; l++) begin
                    if (lane_valid[l] && lane_ready[l]) begin
                        acc_cnt++;
                        due_q[l].push_back(ncyc + 5);
                        check("sb_has_row", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("lane", 64'(lane_valid), 64'(1) << e.lane);
                            check("row", 64'(job_row), 64'(e.row));
                            check("a_addr", job_a_addr, e.a);
                            check("o_addr", job_o_addr, e.o);
                        end
                    end
                end
            end
        end
    end

    task automatic start_job(input int m, input int n, input int k, input bit push);
        calc_begin = 1'b1;
        M_num = m;
        N_num = n;
        K_num = k;
        if (push) begin
            job_m = (m != 0 && n != 0 && k != 0) ? m : 0;
            delivered = 0;
            for (int r = 0; r < job_m; r++) begin
                exp_q.push_back('{r % NL, 32'(r),
                                  A_BASE + 64'(r) * 64'(k) * 64'd2,
                                  O_BASE + 64'(r) * 64'(n) * 64'd2});
            end
        end
        step();
        calc_begin = 1'b0;
        #2;
        if (push) begin
            check("busy_start", 64'(busy), 64'd1);
            check("err_clear", 64'(err), 64'd0);
        end
    endtask

    task automatic do_b(input int n, input int k);
        check("bvalid_t1", 64'(b_req_valid), 64'd0);
        step(); #2;
        check("bvalid_t2", 64'(b_req_valid), 64'd1);
        check("b_len", 64'(b_req_len), 64'(32'(n * k * 2)));
        check("b_addr", b_req_addr, 64'd0);
        step(); #2;
        check("bvalid_ack", 64'(b_req_valid), 64'd0);
        b_done = 1'b1;
        step();
        b_done = 1'b0;
    endtask

    task automatic wait_row(input int r, input int budget);
        int n = 0;
        while (job_row < 32'(r) && n < budget) begin
            step(); #2;
            n++;
        end
        check("row_reached", 64'(job_row >= 32'(r)), 64'd1);
    endtask

    task automatic wait_end(input int budget);
        int e0 = end_cnt;
        int n = 0;
        while (end_cnt == e0 && n < budget) begin
            step(); #2;
            n++;
        end
        check("end_seen", 64'(end_cnt - e0), 64'd1);
        repeat (3) step();
        #2;
        check("end_once", 64'(end_cnt - e0), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int a0, bv0, lv0;
        rst = 1'b1;
        calc_begin = 1'b0;
        M_num = '0;
        N_num = '0;
        K_num = '0;
        b_req_ready = 1'b1;
        b_done = 1'b0;
        lane_ready = '1;
        repeat (3) step();
        rst = 1'b0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_end", 64'(calc_end), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_bvalid", 64'(b_req_valid), 64'd0);
        check("rst_lvalid", 64'(lane_valid), 64'd0);
        check("rst_a_addr", job_a_addr, 64'd0);

        // Basic job across all four lanes
        step();
        start_job(8, 4, 16, 1);
        do_b(4, 16);
        wait_end(100);

        // Zero dimension: straight to calc_end, begin in calc_end cycle ignored
        step();
        bv0 = bv_cnt;
        lv0 = lv_cnt;
        start_job(4, 4, 0, 1);
        check("z_end_t1", 64'(calc_end), 64'd0);
        step(); #2;
        check("z_end_t2", 64'(calc_end), 64'd0);
        step();
        calc_begin = 1'b1;
        M_num = 3;
        N_num = 3;
        K_num = 3;
        #2;
        check("z_end_t3", 64'(calc_end), 64'd1);
        check("z_busy_t3", 64'(busy), 64'd1);
        step();
        calc_begin = 1'b0;
        #2;
        check("z_end_t4", 64'(calc_end), 64'd0);
        check("z_begin_ignored", 64'(busy), 64'd0);
        repeat (4) step();
        #2;
        check("z_no_bvalid", 64'(bv_cnt - bv0), 64'd0);
        check("z_no_lvalid", 64'(lv_cnt - lv0), 64'd0);
        check("z_still_idle", 64'(busy), 64'd0);

        // Lane 1 withholds completions: stall at row 9, spurious done on lane 2
        step();
        a0 = acc_cnt;
        hold = 4'b0010;
        start_job(12, 1, 1, 1);
        do_b(1, 1);
        repeat (40) step();
        #2;
        check("stall_row", 64'(job_row), 64'd9);
        check("stall_lvalid", 64'(lane_valid), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_acc", 64'(acc_cnt - a0), 64'd9);
        check("err_before", 64'(err), 64'd0);
        inj = 4'b0100;
        step();
        step(); #2;
        check("err_set", 64'(err), 64'd1);
        check("stall_row_hold", 64'(job_row), 64'd9);
        hold = '0;
        wait_end(100);
        check("err_sticky", 64'(err), 64'd1);

        // Same-cycle dispatch and done on lane 0 plus done on lanes 1 and 3
        step();
        a0 = acc_cnt;
        hold = '1;
        start_job(9, 2, 3, 1);
        do_b(2, 3);
        wait_row(1, 20);
        lane_ready = 4'b1110;
        repeat (10) step();
        #2;
        check("s5_row", 64'(job_row), 64'd4);
        check("s5_lvalid", 64'(lane_valid), 64'd1);
        check("s5_acc", 64'(acc_cnt - a0), 64'd4);
        kick = 4'b1011;
        step();
        lane_ready = '1;
        repeat (10) step();
        #2;
        check("s5_row_after", 64'(job_row), 64'd9);
        check("s5_acc_after", 64'(acc_cnt - a0), 64'd9);
        check("s5_lvalid_after", 64'(lane_valid), 64'd0);
        check("s5_err", 64'(err), 64'd0);
        hold = '0;
        wait_end(100);
        check("s5_err_end", 64'(err), 64'd0);

        // Reset while dispatching row 3, then a fresh short job
        step();
        start_job(8, 4, 4, 1);
        do_b(4, 4);
        wait_row(3, 20);
        rst = 1'b1;
        exp_q.delete();
        for (int l = 0; l < NL; l++) due_q[l].delete();
        step();
        rst = 1'b0;
        #2;
        check("r_busy", 64'(busy), 64'd0);
        check("r_end", 64'(calc_end), 64'd0);
        check("r_err", 64'(err), 64'd0);
        check("r_bvalid", 64'(b_req_valid), 64'd0);
        check("r_lvalid", 64'(lane_valid), 64'd0);
        check("r_row", 64'(job_row), 64'd0);
        check("r_a_addr", job_a_addr, 64'd0);
        check("r_o_addr", job_o_addr, 64'd0);
        check("r_b_len", 64'(b_req_len), 64'd0);
        step();
        start_job(2, 2, 2, 1);
        do_b(2, 2);
        start_job(5, 5, 5, 0);
        wait_end(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
